ncore_emode_ctrl: RTL and testbench
===================================

NCORE_EMODE_CTRL -- requirements
Module: ncore_emode_ctrl

Interface
REQ-001 Parameter MAX_FAILS, default 3, consecutive failed entries that trigger lockout (range 1..15).
REQ-002 Parameter LOCK_CYCLES, default 256, lockout duration in clk cycles (range 1..65535).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 key  input  14  enclave key, stable while not in reset.
REQ-006 ent_req  input  1  one-cycle enclave-entry request from the core.
REQ-007 ent_key  input  14  candidate key, valid with ent_req.
REQ-008 ext_req  input  1  one-cycle enclave-exit request.
REQ-009 rd_req  input  1  one-cycle safe-ROM read request.
REQ-010 rd_addr  input  8  safe-ROM address, valid with rd_req.
REQ-011 rom_en  output  1  safe-ROM read enable.
REQ-012 rom_addr  output  8  safe-ROM address.
REQ-013 rom_data  input  8  safe-ROM data, valid one cycle after rom_en.
REQ-014 rd_valid  output  1  read-response strobe.
REQ-015 rd_data  output  32  read data, zero-extended rom_data.
REQ-016 rd_err  output  1  read denied, qualified by rd_valid.
REQ-017 emode  output  1  enclave mode active.
REQ-018 ent_done  output  1  one-cycle entry-result strobe.
REQ-019 ent_fail  output  1  entry result (0 pass, 1 fail), qualified by ent_done; it is the core's r3 value.
REQ-020 locked  output  1  lockout active.

Function
REQ-021 FSM states: IDLE, CHECK, ENCLAVE, LOCKED; encoding is free.
REQ-022 IDLE + ent_req: ent_key registered; next state CHECK.
REQ-023 CHECK: compare the registered ent_key with key; on the next cycle ent_done=1.
REQ-024 On a match: ent_fail=0, emode=1 on that same cycle, state ENCLAVE, fail counter cleared.
REQ-025 On a mismatch: ent_fail=1 and the fail counter increments (4 bits, saturating); the next state is LOCKED if the counter reaches MAX_FAILS, else IDLE.
REQ-026 Entry latency: ent_req in cycle N gives ent_done in cycle N+2.
REQ-027 ENCLAVE + ent_req: ent_done=1 and ent_fail=0 next cycle; the state is unchanged.
REQ-028 ENCLAVE + ext_req: emode=0 next cycle; the state returns to IDLE.
REQ-029 ENCLAVE + ent_req and ext_req in the same cycle: the exit takes priority and the ent_req is dropped (no ent_done).
REQ-030 In IDLE, CHECK and LOCKED, ext_req is ignored.
REQ-031 In CHECK, ent_req is ignored and produces no ent_done.
REQ-032 LOCKED: locked=1; the 16-bit counter loads LOCK_CYCLES-1 on entry and decrements each cycle.
REQ-033 LOCKED, counter at 0: next state IDLE, fail counter cleared, locked=0.
REQ-034 LOCKED + ent_req: ent_done=1 and ent_fail=1 next cycle; the key is not compared, the lock counter is not reloaded and the fail counter is unchanged.
REQ-035 rd_req while emode=1: rom_en=1 and rom_addr=rd_addr combinationally in that cycle; next cycle rd_valid=1, rd_data={24'b0,rom_data}, rd_err=0.
REQ-036 rd_req while emode=0: rom_en stays 0; next cycle rd_valid=1, rd_data=0, rd_err=1.
REQ-037 rd_req in the same cycle as an accepted ext_req: the read is granted, because emode is sampled before the exit.
REQ-038 Back-to-back rd_req every cycle is accepted with a throughput of 1 per cycle; no backpressure.
REQ-039 rom_addr holds its last value when rom_en=0.

Reset
REQ-040 rst=1 forces state IDLE; emode, ent_done, ent_fail, rd_valid, rd_err, rom_en and locked are 0; rd_data, rom_addr and both counters are 0.
REQ-041 Reset mid-CHECK or mid-LOCKED aborts the operation, produces no ent_done and clears the fail counter.
REQ-042 A rd_req pending at reset produces no rd_valid.

Configuration
REQ-043 Macro NCORE_EMODE_LOCKOUT_EN defined: lockout behaviour per REQ-025 and REQ-032 to REQ-034.
REQ-044 NCORE_EMODE_LOCKOUT_EN undefined: the LOCKED state and lock counter are absent, a mismatch always returns to IDLE, and locked is tied to 0.

Verification
REQ-045 key=0x1A2B, ent_req with ent_key=0x1A2B in cycle 10 -> ent_done=1 and ent_fail=0 at cycle 12, emode=1.
REQ-046 emode=1, rd_req with rd_addr=0x05 and ROM[5]=0x66 -> next cycle rd_valid=1, rd_data=0x00000066, rd_err=0.
REQ-047 emode=0, rd_req with rd_addr=0x05 -> rom_en=0; next cycle rd_valid=1, rd_data=0, rd_err=1.
REQ-048 NCORE_EMODE_LOCKOUT_EN defined, MAX_FAILS=3, LOCK_CYCLES=16, three wrong keys -> third ent_fail=1 and locked=1; a correct key while locked -> ent_fail=1; locked=0 after 16 cycles; then a correct key -> emode=1.
REQ-049 emode=1, ext_req and rd_req in the same cycle -> read granted (rd_err=0), emode=0 next cycle; a following rd_req -> rd_err=1.
REQ-050 rst asserted one cycle after ent_req -> no ent_done, emode=0, state IDLE.

Source files
------------

// File: rtl/ncore_emode_ctrl_if.sv
// ncore_emode_ctrl_if: core and safe-ROM signal bundle for the enclave-mode controller
interface ncore_emode_ctrl_if;
    logic [13:0] key;
    logic        ent_req;
    logic [13:0] ent_key;
    logic        ext_req;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        emode;
    logic        ent_done;
    logic        ent_fail;
    logic        locked;
    modport slave (
        input  key, ent_req, ent_key, ext_req, rd_req, rd_addr, rom_data,
        output rom_en, rom_addr, rd_valid, rd_data, rd_err, emode, ent_done, ent_fail, locked
    );
    modport master (
        output key, ent_req, ent_key, ext_req, rd_req, rd_addr, rom_data,
        input  rom_en, rom_addr, rd_valid, rd_data, rd_err, emode, ent_done, ent_fail, locked
    );
endinterface

// File: rtl/ncore_emode_ctrl.sv
// ncore_emode_ctrl: enclave entry/exit control with key check and gated safe-ROM reads
// Optional failed-entry lockout is enabled by defining NCORE_EMODE_LOCKOUT_EN.
module ncore_emode_ctrl #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 256
) (
    input logic               clk,
    input logic               rst,
    ncore_emode_ctrl_if.slave bus
);
`ifdef NCORE_EMODE_LOCKOUT_EN
    typedef enum logic [1:0] {IDLE, CHECK, ENCLAVE, LOCKED} state_t;
    localparam logic [3:0]  MAX_F = 4'(MAX_FAILS);
    localparam logic [15:0] LOAD  = 16'(LOCK_CYCLES - 1);
    logic [15:0] lcnt_q, lcnt_d;
`else
    typedef enum logic [1:0] {IDLE, CHECK, ENCLAVE} state_t;
`endif
    state_t      state_q, state_d;
    logic [13:0] ekey_q;
    logic [3:0]  fails_q, fails_d, fail_inc;
    logic        ent_done_q, ent_done_d, ent_fail_q, ent_fail_d;
    logic        rd_valid_q, rd_err_q;
    logic [7:0]  rom_addr_q;
    logic        emode, rom_en;

    assign emode        = state_q == ENCLAVE;
    assign rom_en       = bus.rd_req & emode;
    assign bus.emode    = emode;
    assign bus.rom_en   = rom_en;
    assign bus.rom_addr = rom_en ? bus.rd_addr : rom_addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_data  = (rd_valid_q && !rd_err_q) ? {24'b0, bus.rom_data} : 32'b0;
    assign bus.ent_done = ent_done_q;
    assign bus.ent_fail = ent_fail_q;
`ifdef NCORE_EMODE_LOCKOUT_EN
    assign bus.locked   = state_q == LOCKED;
`else
    assign bus.locked   = 1'b0;
`endif
    assign fail_inc = (fails_q == 4'hF) ? 4'hF : fails_q + 4'd1;

    // Next state, entry result strobe and failed-entry bookkeeping
    always_comb begin
        state_d    = state_q;
        fails_d    = fails_q;
        ent_done_d = 1'b0;
        ent_fail_d = 1'b0;
`ifdef NCORE_EMODE_LOCKOUT_EN
        lcnt_d     = lcnt_q;
`endif
        unique case (state_q)
            IDLE: state_d = bus.ent_req ? CHECK : IDLE;
            CHECK: begin
                ent_done_d = 1'b1;
                ent_fail_d = ekey_q != bus.key;
                state_d    = ent_fail_d ? IDLE : ENCLAVE;
                fails_d    = ent_fail_d ? fail_inc : 4'd0;
`ifdef NCORE_EMODE_LOCKOUT_EN
                if (ent_fail_d && fail_inc >= MAX_F) begin
                    state_d = LOCKED;
                    lcnt_d  = LOAD;
                end
`endif
            end
            ENCLAVE: begin
                // exit wins over a simultaneous entry request, which is dropped
                state_d    = bus.ext_req ? IDLE : ENCLAVE;
                ent_done_d = bus.ent_req & ~bus.ext_req;
            end
`ifdef NCORE_EMODE_LOCKOUT_EN
            LOCKED: begin
                // entry attempts while locked are refused without a key compare
                ent_done_d = bus.ent_req;
                ent_fail_d = bus.ent_req;
                lcnt_d     = lcnt_q - 16'd1;
                if (lcnt_q == 16'd0) begin
                    state_d = IDLE;
                    fails_d = 4'd0;
                    lcnt_d  = 16'd0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, key capture, read response and ROM address hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ekey_q     <= 14'd0;
            fails_q    <= 4'd0;
            ent_done_q <= 1'b0;
            ent_fail_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rom_addr_q <= 8'd0;
`ifdef NCORE_EMODE_LOCKOUT_EN
            lcnt_q     <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            fails_q    <= fails_d;
            ent_done_q <= ent_done_d;
            ent_fail_q <= ent_fail_d;
            rd_valid_q <= bus.rd_req;
            rd_err_q   <= bus.rd_req & ~emode;
            if (state_q == IDLE && bus.ent_req) ekey_q <= bus.ent_key;
            if (rom_en) rom_addr_q <= bus.rd_addr;
`ifdef NCORE_EMODE_LOCKOUT_EN
            lcnt_q     <= lcnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_ncore_emode_ctrl.sv
// tb_ncore_emode_ctrl: directed self-checking bench for ncore_emode_ctrl
module tb_ncore_emode_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ncore_emode_ctrl_if bus ();

    ncore_emode_ctrl #(.MAX_FAILS(3), .LOCK_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // safe-ROM model: ROM[a] = a ^ 0x63, data one cycle after the address
    always @(posedge clk) bus.rom_data <= bus.rom_addr ^ 8'h63;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.key = 14'h1A2B;
        bus.ent_req = 1'b0;
        bus.ent_key = 14'h0;
        bus.ext_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_addr = 8'h0;
        step(3);
        chk("rst_emode", bus.emode, 0);
        chk("rst_ent_done", bus.ent_done, 0);
        chk("rst_ent_fail", bus.ent_fail, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_rom_en", bus.rom_en, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        rst = 1'b0;
        step(6);
        bus.ent_req = 1'b1;
        bus.ent_key = 14'h1A2B;
        step;
        bus.ent_req = 1'b0;
        chk("ent_lat1_done", bus.ent_done, 0);
        step;
        chk("ent_done", bus.ent_done, 1);
        chk("ent_fail", bus.ent_fail, 0);
        chk("ent_emode", bus.emode, 1);
        bus.rd_req = 1'b1;
        bus.rd_addr = 8'h05;
        #1;
        chk("rd_rom_en", bus.rom_en, 1);
        chk("rd_rom_addr", bus.rom_addr, 8'h05);
        step;
        bus.rd_req = 1'b0;
        chk("rd_valid", bus.rd_valid, 1);
        chk("rd_data", bus.rd_data, 32'h66);
        chk("rd_err", bus.rd_err, 0);
        chk("ent_done_pulse", bus.ent_done, 0);
        bus.rd_req = 1'b1;
        bus.rd_addr = 8'h10;
        step;
        bus.rd_addr = 8'h11;
        chk("b2b0_valid", bus.rd_valid, 1);
        chk("b2b0_data", bus.rd_data, 32'h73);
        step;
        bus.rd_req = 1'b0;
        chk("b2b1_valid", bus.rd_valid, 1);
        chk("b2b1_data", bus.rd_data, 32'h72);
        #1;
        chk("hold_rom_en", bus.rom_en, 0);
        chk("hold_rom_addr", bus.rom_addr, 8'h11);
        bus.ent_req = 1'b1;
        step;
        bus.ent_req = 1'b0;
        chk("enc_ent_done", bus.ent_done, 1);
        chk("enc_ent_fail", bus.ent_fail, 0);
        chk("enc_emode", bus.emode, 1);
        bus.ent_req = 1'b1;
        bus.ext_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_addr = 8'h05;
        #1;
        chk("exit_rom_en", bus.rom_en, 1);
        step;
        bus.ent_req = 1'b0;
        bus.ext_req = 1'b0;
        bus.rd_req = 1'b0;
        chk("exit_rd_valid", bus.rd_valid, 1);
        chk("exit_rd_err", bus.rd_err, 0);
        chk("exit_rd_data", bus.rd_data, 32'h66);
        chk("exit_emode", bus.emode, 0);
        chk("exit_no_done", bus.ent_done, 0);
        bus.rd_req = 1'b1;
        #1;
        chk("deny_rom_en", bus.rom_en, 0);
        step;
        bus.rd_req = 1'b0;
        chk("deny_rd_valid", bus.rd_valid, 1);
        chk("deny_rd_err", bus.rd_err, 1);
        chk("deny_rd_data", bus.rd_data, 0);
        bus.ext_req = 1'b1;
        step;
        bus.ext_req = 1'b0;
        chk("idle_ext_emode", bus.emode, 0);
        bus.ent_key = 14'h1A2A;
        bus.ent_req = 1'b1;
        step;
        step;
        bus.ent_req = 1'b0;
        chk("w1_done", bus.ent_done, 1);
        chk("w1_fail", bus.ent_fail, 1);
        chk("w1_locked", bus.locked, 0);
        chk("w1_emode", bus.emode, 0);
        step;
        chk("w1_check_ignored", bus.ent_done, 0);
        bus.ent_req = 1'b1;
        step;
        bus.ent_req = 1'b0;
        step;
        chk("w2_fail", bus.ent_fail, 1);
        chk("w2_locked", bus.locked, 0);
        bus.ent_req = 1'b1;
        step;
        bus.ent_req = 1'b0;
        step;
        chk("w3_done", bus.ent_done, 1);
        chk("w3_fail", bus.ent_fail, 1);
        bus.ent_key = 14'h1A2B;
`ifdef NCORE_EMODE_LOCKOUT_EN
        chk("w3_locked", bus.locked, 1);
        bus.ent_req = 1'b1;
        step;
        bus.ent_req = 1'b0;
        chk("lk_done", bus.ent_done, 1);
        chk("lk_fail", bus.ent_fail, 1);
        chk("lk_emode", bus.emode, 0);
        step(14);
        chk("lk_hold", bus.locked, 1);
        step;
        chk("lk_release", bus.locked, 0);
`else
        chk("w3_locked", bus.locked, 0);
`endif
        bus.ent_req = 1'b1;
        step;
        bus.ent_req = 1'b0;
        step;
        chk("post_done", bus.ent_done, 1);
        chk("post_fail", bus.ent_fail, 0);
        chk("post_emode", bus.emode, 1);
        bus.ext_req = 1'b1;
        step;
        bus.ext_req = 1'b0;
        chk("post_exit_emode", bus.emode, 0);
        bus.ent_req = 1'b1;
        step;
        bus.ent_req = 1'b0;
        rst = 1'b1;
        bus.rd_req = 1'b1;
        step;
        rst = 1'b0;
        bus.rd_req = 1'b0;
        chk("rstc_done", bus.ent_done, 0);
        chk("rstc_emode", bus.emode, 0);
        chk("rstc_rd_valid", bus.rd_valid, 0);
        step;
        chk("rstc_done2", bus.ent_done, 0);
        chk("rstc_emode2", bus.emode, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
